byte_lane_collector: RTL and testbench

BYTE_LANE_COLLECTOR -- requirements
Module: byte_lane_collector

---
 rtl/byte_lane_collector_pkg.sv | 46 ++++
 rtl/byte_fifo_mw.sv | 115 +++++++++++
 rtl/byte_lane_collector.sv | 218 +++++++++++++++++++++
 tb/tb_byte_lane_collector.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_lane_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_collector_pkg
//  Description : Shared definitions for the byte lane collector: legal lane
//                and gear values, bytes-per-cycle and FIFO address width
//                helpers, and the input FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package byte_lane_collector_pkg;

    // Legal lane counts
    localparam int c_LANE_1  = 1;
    localparam int c_LANE_2  = 2;
    localparam int c_LANE_4  = 4;

    // Legal lane gears (bits per lane per cycle)
    localparam int c_GEAR_8  = 8;
    localparam int c_GEAR_16 = 16;

    // Width of the raw lane bus and of the statistics counters
    localparam int c_DOUT_W  = 64;
    localparam int c_CNT_W   = 32;

    // Bytes delivered by the lanes in one input cycle
    function automatic int bpc_of(input int lanes, input int gear);
        return (lanes * gear) / 8;
    endfunction

    // Address width of a FIFO of the given (power-of-two) depth
    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

    // True when v is a non-zero power of two
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Input FSM: nothing held, or one byte group held in the stage register
    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_STAGED = 1'b1
    } in_state_t;

endpackage : byte_lane_collector_pkg
`default_nettype wire

// File: rtl/byte_fifo_mw.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo_mw
//  Description : Multi-write / single-read byte FIFO. One write stores a whole
//                group of BPC bytes; one read removes a single byte. Every
//                entry carries a "last" bit; only the final byte of a group
//                can have it set. The head is presented first-word-fall-through.
//
//  Ports
//    clk        : clock, rising edge
//    rst_n      : asynchronous active-low reset (pointers to zero)
//    i_clr      : synchronous flush
//    i_wr_en    : write one group (caller guarantees o_free >= BPC)
//    i_wr_data  : group bytes, byte 0 in bits [7:0] is read out first
//    i_wr_last  : last tag for the final byte of the group
//    i_rd_en    : pop the head byte (ignored when empty)
//    o_rd_byte  : head byte, zero when empty
//    o_rd_last  : head last tag, zero when empty
//    o_empty    : FIFO holds no byte
//    o_free     : free byte entries, sampled before any same-cycle read
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo_mw
    import byte_lane_collector_pkg::*;
#(
    parameter  int BPC   = 8,
    parameter  int DEPTH = 32,
    localparam int AW    = fifo_aw(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_wr_en,
    input  logic [BPC*8-1:0]   i_wr_data,
    input  logic               i_wr_last,
    input  logic               i_rd_en,
    output logic [7:0]         o_rd_byte,
    output logic               o_rd_last,
    output logic               o_empty,
    output logic [AW:0]        o_free
);

    // The write pointer only ever moves by BPC and DEPTH is a multiple of
    // BPC, so every group lands on a BPC-aligned row. The storage is
    // therefore organised as DEPTH/BPC rows of BPC entries, written whole.
    localparam int             LOG_BPC   = $clog2(BPC);
    localparam int             ROWS      = DEPTH / BPC;
    localparam logic [AW:0]    c_BPC_PTR = (AW+1)'(BPC);
    localparam logic [AW:0]    c_DEPTH   = (AW+1)'(DEPTH);

    logic [9*BPC-1:0] r_mem [ROWS];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    logic [9*BPC-1:0] w_wr_row;
    logic [9*BPC-1:0] w_rd_row;
    logic [8:0]       w_head;
    logic [AW:0]      w_count;
    logic             w_full;
    logic             w_pop;
    int               w_col;

    // Pack the group into one row; the last tag rides on the final entry.
    for (genvar k = 0; k < BPC; k++) begin : g_wrow
        if (k == BPC - 1) begin : g_tail
            assign w_wr_row[9*k +: 9] = {i_wr_last, i_wr_data[8*k +: 8]};
        end else begin : g_body
            assign w_wr_row[9*k +: 9] = {1'b0, i_wr_data[8*k +: 8]};
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wptr[AW-1:LOG_BPC]] <= w_wr_row;
        end
    end

    // Pointers carry one extra MSB: equal pointers mean empty, pointers that
    // differ only in the MSB mean full.
    assign w_count = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_free  = w_full ? '0 : (c_DEPTH - w_count);
    assign w_pop   = i_rd_en && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_wptr <= r_wptr + c_BPC_PTR;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Head byte: select the row, then the entry within the row.
    always_comb begin
        w_rd_row = r_mem[r_rptr[AW-1:LOG_BPC]];
        w_col    = int'(r_rptr[AW-1:0]) % BPC;
        w_head   = w_rd_row[9*w_col +: 9];
    end

    assign o_rd_byte = o_empty ? 8'h00 : w_head[7:0];
    assign o_rd_last = !o_empty && w_head[8];

endmodule : byte_fifo_mw
`default_nettype wire

// File: rtl/byte_lane_collector.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_collector
//  Description : Collects BPC bytes per cycle from up to four TX lanes,
//                buffers them in a byte FIFO and serialises them one byte per
//                cycle over a valid/ready interface. Bursts (runs of byte_en)
//                are framed with out_last / pkt_done and counted.
//
//  Ports
//    byte_clk          : clock, rising edge
//    reset_n           : asynchronous active-low reset
//    byte_en           : lane data valid
//    byte_dout[63:0]   : lane data, lane L in bits [16L+15:16L]
//    clr               : synchronous clear of FIFO, stage, counters, overflow
//    out_ready         : downstream ready
//    out_valid         : out_byte holds a valid byte
//    out_byte[7:0]     : serialised byte
//    out_last          : final byte of a burst
//    pkt_done          : one-cycle pulse when a burst is closed
//    pkt_byte_count    : bytes accepted in the last closed burst
//    total_byte_count  : bytes accepted since reset or clr (wraps)
//    overflow          : sticky, a byte group was dropped for lack of space
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_collector
    import byte_lane_collector_pkg::*;
#(
    parameter int NUM_TX_LANE = 4,
    parameter int TX_GEAR     = 16,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                byte_clk,
    input  logic                reset_n,
    input  logic                byte_en,
    input  logic [c_DOUT_W-1:0] byte_dout,
    input  logic                clr,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [7:0]          out_byte,
    output logic                out_last,
    output logic                pkt_done,
    output logic [c_CNT_W-1:0]  pkt_byte_count,
    output logic [c_CNT_W-1:0]  total_byte_count,
    output logic                overflow
);

    localparam int                 BPC       = bpc_of(NUM_TX_LANE, TX_GEAR);
    localparam int                 AW        = fifo_aw(FIFO_DEPTH);
    localparam logic [AW:0]        c_BPC_PTR = (AW+1)'(BPC);
    localparam logic [c_CNT_W-1:0] c_BPC_CNT = c_CNT_W'(BPC);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!(NUM_TX_LANE == c_LANE_1 || NUM_TX_LANE == c_LANE_2 ||
          NUM_TX_LANE == c_LANE_4)) begin : g_bad_lanes
        $fatal(1, "byte_lane_collector: NUM_TX_LANE must be 1, 2 or 4");
    end
    if (!(TX_GEAR == c_GEAR_8 || TX_GEAR == c_GEAR_16)) begin : g_bad_gear
        $fatal(1, "byte_lane_collector: TX_GEAR must be 8 or 16");
    end
    if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 2 * BPC)) begin : g_bad_depth
        $fatal(1, "byte_lane_collector: FIFO_DEPTH must be a power of 2 >= 2*BPC");
    end

    // ------------------------------------------------------------------
    // Lane-to-byte mapping: low bytes of lanes 0..N-1 first, then (gear 16
    // only) the high bytes of lanes 0..N-1.
    // ------------------------------------------------------------------
    logic [BPC*8-1:0] w_group;
    logic             w_dout_unused;

    for (genvar k = 0; k < BPC; k++) begin : g_byte
        if (k < NUM_TX_LANE) begin : g_low
            assign w_group[8*k +: 8] = byte_dout[16*k +: 8];
        end else begin : g_high
            assign w_group[8*k +: 8] = byte_dout[16*(k-NUM_TX_LANE)+8 +: 8];
        end
    end

    // Lanes/halves above the configured geometry are intentionally ignored.
    assign w_dout_unused = ^byte_dout;

    // ------------------------------------------------------------------
    // Input FSM
    // ------------------------------------------------------------------
    in_state_t        r_state;
    in_state_t        w_state_nxt;
    logic [BPC*8-1:0] r_stage;
    logic             w_wr_req;
    logic             w_burst_end;

    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else if (clr) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY:  if (byte_en)  w_state_nxt = ST_STAGED;
            ST_STAGED: if (!byte_en) w_state_nxt = ST_EMPTY;
            default:                 w_state_nxt = ST_EMPTY;
        endcase
    end

    // A staged group is always offered to the FIFO; it closes the burst when
    // no new group arrives behind it.
    always_comb begin
        w_wr_req    = 1'b0;
        w_burst_end = 1'b0;
        if (r_state == ST_STAGED) begin
            w_wr_req    = 1'b1;
            w_burst_end = !byte_en;
        end
    end

    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= '0;
        end else if (byte_en && !clr) begin
            r_stage <= w_group;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [AW:0] w_free;
    logic        w_empty;
    logic        w_space_ok;
    logic        w_wr_en;
    logic        w_drop;
    logic        w_rd_en;

    // Space is judged on the pre-read occupancy so a full FIFO being drained
    // this cycle still rejects the group.
    assign w_space_ok = (w_free >= c_BPC_PTR);
    assign w_wr_en    = w_wr_req && w_space_ok && !clr;
    assign w_drop     = w_wr_req && !w_space_ok && !clr;
    assign out_valid  = !w_empty;
    assign w_rd_en    = out_valid && out_ready && !clr;

    byte_fifo_mw #(
        .BPC   (BPC),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (byte_clk),
        .rst_n     (reset_n),
        .i_clr     (clr),
        .i_wr_en   (w_wr_en),
        .i_wr_data (r_stage),
        .i_wr_last (w_burst_end),
        .i_rd_en   (w_rd_en),
        .o_rd_byte (out_byte),
        .o_rd_last (out_last),
        .o_empty   (w_empty),
        .o_free    (w_free)
    );

    // ------------------------------------------------------------------
    // Burst and total counters
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_run;
    logic [c_CNT_W-1:0] r_pkt;
    logic [c_CNT_W-1:0] r_total;
    logic               r_done;
    logic               r_ovf;
    logic [c_CNT_W-1:0] w_run_inc;

    // A dropped group adds nothing, but still closes the burst if it was last.
    assign w_run_inc = r_run + (w_wr_en ? c_BPC_CNT : '0);

    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run   <= '0;
            r_pkt   <= '0;
            r_total <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_run   <= '0;
            r_pkt   <= '0;
            r_total <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wr_en) begin
                r_total <= r_total + c_BPC_CNT;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_wr_req) begin
                if (w_burst_end) begin
                    r_pkt  <= w_run_inc;
                    r_done <= 1'b1;
                    r_run  <= '0;
                end else begin
                    r_run  <= w_run_inc;
                end
            end
        end
    end

    assign pkt_done         = r_done;
    assign pkt_byte_count   = r_pkt;
    assign total_byte_count = r_total;
    assign overflow         = r_ovf;

endmodule : byte_lane_collector
`default_nettype wire

// File: tb/tb_byte_lane_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_lane_collector
//  Description : Self-checking bench. Four collectors with different lane /
//                gear / depth geometries share one stimulus; each is compared
//                every cycle against a queue-based reference model, plus a
//                small vector table and directed burst scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_lane_collector;

    localparam int NI = 4;

    logic        byte_clk  = 1'b0;
    logic        reset_n   = 1'b0;
    logic        byte_en   = 1'b0;
    logic [63:0] byte_dout = '0;
    logic        clr       = 1'b0;
    logic        out_ready = 1'b0;

    logic [NI-1:0] dv, dl, dpd, dov;
    logic [7:0]    db   [NI];
    logic [31:0]   dpk  [NI];
    logic [31:0]   dtot [NI];

    always #5 byte_clk = ~byte_clk;

    byte_lane_collector #(.NUM_TX_LANE(4), .TX_GEAR(16), .FIFO_DEPTH(32)) u_dut0 (
        .byte_clk(byte_clk), .reset_n(reset_n), .byte_en(byte_en), .byte_dout(byte_dout),
        .clr(clr), .out_ready(out_ready), .out_valid(dv[0]), .out_byte(db[0]),
        .out_last(dl[0]), .pkt_done(dpd[0]), .pkt_byte_count(dpk[0]),
        .total_byte_count(dtot[0]), .overflow(dov[0]));
    byte_lane_collector #(.NUM_TX_LANE(2), .TX_GEAR(8), .FIFO_DEPTH(8)) u_dut1 (
        .byte_clk(byte_clk), .reset_n(reset_n), .byte_en(byte_en), .byte_dout(byte_dout),
        .clr(clr), .out_ready(out_ready), .out_valid(dv[1]), .out_byte(db[1]),
        .out_last(dl[1]), .pkt_done(dpd[1]), .pkt_byte_count(dpk[1]),
        .total_byte_count(dtot[1]), .overflow(dov[1]));
    byte_lane_collector #(.NUM_TX_LANE(1), .TX_GEAR(16), .FIFO_DEPTH(32)) u_dut2 (
        .byte_clk(byte_clk), .reset_n(reset_n), .byte_en(byte_en), .byte_dout(byte_dout),
        .clr(clr), .out_ready(out_ready), .out_valid(dv[2]), .out_byte(db[2]),
        .out_last(dl[2]), .pkt_done(dpd[2]), .pkt_byte_count(dpk[2]),
        .total_byte_count(dtot[2]), .overflow(dov[2]));
    byte_lane_collector #(.NUM_TX_LANE(4), .TX_GEAR(8), .FIFO_DEPTH(16)) u_dut3 (
        .byte_clk(byte_clk), .reset_n(reset_n), .byte_en(byte_en), .byte_dout(byte_dout),
        .clr(clr), .out_ready(out_ready), .out_valid(dv[3]), .out_byte(db[3]),
        .out_last(dl[3]), .pkt_done(dpd[3]), .pkt_byte_count(dpk[3]),
        .total_byte_count(dtot[3]), .overflow(dov[3]));

    function automatic int cfg_n(input int i);
        case (i) 0: return 4; 1: return 2; 2: return 1; default: return 4; endcase
    endfunction
    function automatic int cfg_g(input int i);
        case (i) 0: return 16; 1: return 8; 2: return 16; default: return 8; endcase
    endfunction
    function automatic int cfg_d(input int i);
        case (i) 0: return 32; 1: return 8; 2: return 32; default: return 16; endcase
    endfunction
    function automatic int cfg_bpc(input int i);
        return cfg_n(i) * cfg_g(i) / 8;
    endfunction

    // Byte k of a group: gear 8 -> lane k low; gear 16 -> lane (k mod N),
    // low half for k < N, high half otherwise.
    function automatic logic [7:0] ref_byte(input int n, input int g,
                                            input logic [63:0] d, input int k);
        int lane;
        int half;
        if (g == 8) begin
            lane = k;
            half = 0;
        end else begin
            lane = k % n;
            half = k / n;
        end
        return d[16*lane + 8*half +: 8];
    endfunction

    // ---------------- reference model ----------------
    logic [8:0]  mq    [NI][64];
    int          mhead [NI];
    int          mcnt  [NI];
    bit          mst_v [NI];
    logic [63:0] mst_d [NI];
    logic [31:0] mtot  [NI];
    logic [31:0] mrun  [NI];
    logic [31:0] mpkt  [NI];
    bit          mdone [NI];
    bit          movf  [NI];

    logic [7:0]  cap_b [NI][64];
    bit          cap_l [NI][64];
    int          ncap  [NI];
    bit          done_seen [NI];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int i, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %0h expected %0h", nm, i, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mhead[i] = 0; mcnt[i] = 0; mst_v[i] = 0; mst_d[i] = '0;
            mtot[i] = '0; mrun[i] = '0; mpkt[i] = '0; mdone[i] = 0; movf[i] = 0;
        end
    endtask

    task automatic clr_cap();
        for (int i = 0; i < NI; i++) begin
            ncap[i] = 0;
            done_seen[i] = 0;
        end
    endtask

    // Advance model instance i across one clock edge using current inputs.
    task automatic model_edge(input int i);
        int  bpc;
        int  free;
        bit  rd;
        bpc      = cfg_bpc(i);
        mdone[i] = 0;
        if (clr) begin
            mhead[i] = 0; mcnt[i] = 0; mst_v[i] = 0;
            mtot[i] = '0; mrun[i] = '0; mpkt[i] = '0; movf[i] = 0;
            return;
        end
        rd   = (mcnt[i] > 0) && out_ready;
        free = cfg_d(i) - mcnt[i];
        if (rd) begin
            mhead[i] = (mhead[i] + 1) % 64;
            mcnt[i]  = mcnt[i] - 1;
        end
        if (mst_v[i]) begin
            if (free >= bpc) begin
                for (int k = 0; k < bpc; k++) begin
                    mq[i][(mhead[i] + mcnt[i]) % 64] =
                        {((k == bpc - 1) && !byte_en),
                         ref_byte(cfg_n(i), cfg_g(i), mst_d[i], k)};
                    mcnt[i] = mcnt[i] + 1;
                end
                mtot[i] = mtot[i] + 32'(bpc);
                mrun[i] = mrun[i] + 32'(bpc);
            end else begin
                movf[i] = 1;
            end
            if (!byte_en) begin
                mpkt[i]  = mrun[i];
                mdone[i] = 1;
                mrun[i]  = '0;
            end
        end
        mst_v[i] = byte_en;
        mst_d[i] = byte_dout;
    endtask

    task automatic compare_all(input int i);
        chk("out_valid", i, 64'(dv[i]), 64'(mcnt[i] > 0));
        if (mcnt[i] > 0) begin
            chk("out_byte", i, 64'(db[i]), 64'(mq[i][mhead[i]][7:0]));
            chk("out_last", i, 64'(dl[i]), 64'(mq[i][mhead[i]][8]));
        end
        chk("pkt_done", i, 64'(dpd[i]), 64'(mdone[i]));
        chk("pkt_byte_count", i, 64'(dpk[i]), 64'(mpkt[i]));
        chk("total_byte_count", i, 64'(dtot[i]), 64'(mtot[i]));
        chk("overflow", i, 64'(dov[i]), 64'(movf[i]));
        if (dpd[i]) done_seen[i] = 1;
    endtask

    // One clock: record transfers and step the model before the edge,
    // then compare every instance 1 time unit after it.
    task automatic step();
        for (int i = 0; i < NI; i++) begin
            if (dv[i] && out_ready && !clr && ncap[i] < 64) begin
                cap_b[i][ncap[i]] = db[i];
                cap_l[i][ncap[i]] = dl[i];
                ncap[i]++;
            end
            model_edge(i);
        end
        @(posedge byte_clk);
        #1;
        for (int i = 0; i < NI; i++) compare_all(i);
    endtask

    task automatic do_clr();
        clr     = 1'b1;
        byte_en = 1'b0;
        step();
        clr     = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [63:0] dout;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] e3;
    } vec_t;

    function automatic logic [63:0] pick(input vec_t v, input int i);
        case (i) 0: return v.e0; 1: return v.e1; 2: return v.e2; default: return v.e3; endcase
    endfunction

    vec_t        tbl [3];
    logic [63:0] rec [10];
    logic [63:0] got;
    logic [63:0] lm;

    initial begin
        // Expected bytes packed with the first delivered byte in bits [7:0].
        tbl[0] = '{64'h0706_0504_0302_0100, 64'h0705_0301_0604_0200,
                   64'h0200, 64'h0100, 64'h0604_0200};
        tbl[1] = '{64'hFEDC_BA98_7654_3210, 64'hFEBA_7632_DC98_5410,
                   64'h5410, 64'h3210, 64'hDC98_5410};
        tbl[2] = '{64'hA5A5_0000_FFFF_1234, 64'hA500_FF12_A500_FF34,
                   64'hFF34, 64'h1234, 64'hA500_FF34};

        model_reset();
        clr_cap();

        // Reset state
        repeat (3) @(posedge byte_clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            compare_all(i);
            chk("rst_out_byte", i, 64'(db[i]), 64'h0);
            chk("rst_out_last", i, 64'(dl[i]), 64'h0);
        end
        reset_n = 1'b1;

        // Table: single-cycle bursts, full-rate drain
        out_ready = 1'b1;
        for (int e = 0; e < 3; e++) begin
            clr_cap();
            byte_en   = 1'b1;
            byte_dout = tbl[e].dout;
            step();
            byte_en   = 1'b0;
            repeat (10) step();
            for (int i = 0; i < NI; i++) begin
                got = '0;
                lm  = '0;
                for (int k = 0; k < ncap[i] && k < 8; k++) begin
                    got[8*k +: 8] = cap_b[i][k];
                    lm[k]         = cap_l[i][k];
                end
                chk("tbl_nbytes", i, 64'(ncap[i]), 64'(cfg_bpc(i)));
                chk("tbl_bytes", i, got, pick(tbl[e], i));
                chk("tbl_last", i, lm, 64'(1) << (cfg_bpc(i) - 1));
                chk("tbl_done", i, 64'(done_seen[i]), 64'h1);
                chk("tbl_pkt", i, 64'(dpk[i]), 64'(cfg_bpc(i)));
            end
        end

        // 2 lanes gear 8, 3-cycle burst
        do_clr();
        clr_cap();
        for (int c = 0; c < 3; c++) begin
            byte_en   = 1'b1;
            byte_dout = {$urandom(), $urandom()};
            rec[c]    = byte_dout;
            step();
        end
        byte_en = 1'b0;
        repeat (12) step();
        chk("b3_nbytes", 1, 64'(ncap[1]), 64'd6);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 2; k++) begin
                chk("b3_byte", 1, 64'(cap_b[1][2*c+k]), 64'(ref_byte(2, 8, rec[c], k)));
                chk("b3_last", 1, 64'(cap_l[1][2*c+k]), 64'((2*c+k) == 5));
            end
        end
        chk("b3_total", 1, 64'(dtot[1]), 64'd6);

        // Overflow: 5-cycle burst with the output stalled
        do_clr();
        clr_cap();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            byte_en   = 1'b1;
            byte_dout = {$urandom(), $urandom()};
            step();
        end
        byte_en = 1'b0;
        repeat (3) step();
        chk("ovf_flag", 0, 64'(dov[0]), 64'h1);
        chk("ovf_pkt", 0, 64'(dpk[0]), 64'd32);
        chk("ovf_done", 0, 64'(done_seen[0]), 64'h1);
        chk("ovf_total", 0, 64'(dtot[0]), 64'd32);
        chk("ovf_pkt", 3, 64'(dpk[3]), 64'd16);

        // Asynchronous reset between edges while data is pending
        chk("pre_rst_valid", 0, 64'(dv[0]), 64'h1);
        #3;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("arst_valid", i, 64'(dv[i]), 64'h0);
            chk("arst_byte", i, 64'(db[i]), 64'h0);
            chk("arst_last", i, 64'(dl[i]), 64'h0);
            chk("arst_done", i, 64'(dpd[i]), 64'h0);
            chk("arst_pkt", i, 64'(dpk[i]), 64'h0);
            chk("arst_total", i, 64'(dtot[i]), 64'h0);
            chk("arst_ovf", i, 64'(dov[i]), 64'h0);
        end
        model_reset();
        clr_cap();
        repeat (2) @(posedge byte_clk);
        #1;
        reset_n = 1'b1;

        // Backpressure: 10-cycle burst, random ready
        for (int c = 0; c < 10; c++) begin
            byte_en   = 1'b1;
            byte_dout = {$urandom(), $urandom()};
            rec[c]    = byte_dout;
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        byte_en = 1'b0;
        for (int c = 0; c < 60; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        out_ready = 1'b1;
        repeat (25) step();
        chk("bp_nbytes", 2, 64'(ncap[2]), 64'd20);
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 2; k++) begin
                chk("bp_byte", 2, 64'(cap_b[2][2*c+k]), 64'(ref_byte(1, 16, rec[c], k)));
            end
        end
        chk("bp_last", 2, 64'(cap_l[2][19]), 64'h1);
        chk("bp_pkt", 2, 64'(dpk[2]), 64'd20);
        chk("bp_ovf", 2, 64'(dov[2]), 64'h0);

        // clr in the middle of a burst
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            byte_en   = 1'b1;
            byte_dout = {$urandom(), $urandom()};
            step();
        end
        clr = 1'b1;
        step();
        for (int i = 0; i < NI; i++) begin
            chk("clr_valid", i, 64'(dv[i]), 64'h0);
            chk("clr_pkt", i, 64'(dpk[i]), 64'h0);
            chk("clr_total", i, 64'(dtot[i]), 64'h0);
            chk("clr_ovf", i, 64'(dov[i]), 64'h0);
            chk("clr_done", i, 64'(dpd[i]), 64'h0);
        end
        clr     = 1'b0;
        byte_en = 1'b0;
        clr_cap();
        repeat (5) step();
        chk("clr_no_done", 3, 64'(done_seen[3]), 64'h0);
        for (int c = 0; c < 2; c++) begin
            byte_en   = 1'b1;
            byte_dout = {$urandom(), $urandom()};
            step();
        end
        byte_en = 1'b0;
        repeat (10) step();
        chk("clr_next_pkt", 3, 64'(dpk[3]), 64'd8);
        chk("clr_next_done", 3, 64'(done_seen[3]), 64'h1);

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) byte_en = ~byte_en;
            byte_dout = {$urandom(), $urandom()};
            clr       = ($urandom_range(0, 99) == 0);
            if (((c / 50) % 3) == 2) out_ready = 1'b0;
            else                     out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        clr       = 1'b0;
        byte_en   = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_byte_lane_collector
`default_nettype wire
